// File: rtl/kgprisc_pc_pkg.sv
// Shared types and defaults for the KGPRISC fetch-stage program counter.
package kgprisc_pc_pkg;

    localparam int          PC_WIDTH      = 32;
    localparam logic [31:0] PC_RESET_ADDR = 32'h0;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_BRANCH,
        PC_CALL,
        PC_RET
    } pc_op_t;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: overwrites the oldest entry when full; err pulses on lossy/illegal events.
// Latency 1 cycle; pop has priority over push (a simultaneous push is dropped and flagged).
module pc_ras #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             full,
    output logic             empty,
    output logic             err
);
    localparam int         PW      = $clog2(DEPTH);
    localparam logic [PW:0] CNT_MAX = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW:0]      count;

    // ptr is the next write slot; once full it also addresses the oldest entry.
    assign top_data = mem[ptr - PW'(1)];
    assign full     = (count == CNT_MAX);
    assign empty    = (count == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
            err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            err <= 1'b0;
            if (pop) begin
                if (empty) begin
                    err <= 1'b1;
                end else begin
                    ptr   <= ptr - PW'(1);
                    count <= count - (PW+1)'(1);
                    err   <= push;
                end
            end else if (push) begin
                mem[ptr] <= push_data;
                ptr      <= ptr + PW'(1);
                if (!full) begin
                    count <= count + (PW+1)'(1);
                end
                err <= full;
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: increment, stall hold, branch load, optional RAS (macro PC_RAS_EN).
// Latency 1 cycle, no input-to-pc_out combinational path; stall drops concurrent strobes.
module pc_unit
    import kgprisc_pc_pkg::*;
#(
    parameter int               WIDTH      = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(PC_RESET_ADDR),
    parameter int               INC        = 1,
    parameter int               RAS_DEPTH  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_en,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             call_en,
    input  logic             ret_en,
    output logic [WIDTH-1:0] pc_out,
    output logic             ras_full,
    output logic             ras_empty,
    output logic             ras_err
);
    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    pc_op_t           op;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] top_data;

    assign pc_inc = pc_out + INC_W;

`ifdef PC_RAS_EN
    logic push;
    logic pop;

    always_comb begin
        op = PC_INC;
        if (stall)          op = PC_HOLD;
        else if (ret_en)    op = PC_RET;
        else if (call_en)   op = PC_CALL;
        else if (branch_en) op = PC_BRANCH;
    end

    // A call colliding with a ret is still presented so the stack can flag it.
    assign pop  = (op == PC_RET);
    assign push = (op == PC_CALL) || ((op == PC_RET) && call_en);

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top_data  (top_data),
        .full      (ras_full),
        .empty     (ras_empty),
        .err       (ras_err)
    );
`else
    logic unused_ras;

    always_comb begin
        op = PC_INC;
        if (stall)                     op = PC_HOLD;
        else if (call_en || branch_en) op = PC_BRANCH;
    end

    assign top_data   = '0;
    assign ras_full   = 1'b0;
    assign ras_empty  = 1'b1;
    assign ras_err    = 1'b0;
    assign unused_ras = ret_en ^ (RAS_DEPTH == 0);
`endif

    always_comb begin
        pc_next = pc_inc;
        case (op)
            PC_HOLD:             pc_next = pc_out;
            PC_BRANCH, PC_CALL:  pc_next = branch_target;
            PC_RET:              pc_next = ras_empty ? pc_inc : top_data;
            default:             pc_next = pc_inc;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) pc_out <= RESET_ADDR;
        else       pc_out <= pc_next;
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit; RAS expectations follow the PC_RAS_EN build macro.
module tb_pc_unit;
    logic        clock = 1'b0;
    logic        reset, stall, branch_en, call_en, ret_en;
    logic [31:0] branch_target;
    logic [31:0] pc_out, pc_out2;
    logic        ras_full, ras_empty, ras_err;
    logic        full2, empty2, err2;
    logic        b8_en, zero;
    logic [7:0]  t8, pc8;
    logic        full8, empty8, err8;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clock = ~clock;

    pc_unit dut (
        .clock(clock), .reset(reset), .stall(stall), .branch_en(branch_en),
        .branch_target(branch_target), .call_en(call_en), .ret_en(ret_en),
        .pc_out(pc_out), .ras_full(ras_full), .ras_empty(ras_empty), .ras_err(ras_err)
    );

    pc_unit #(.RESET_ADDR(32'h100)) dut_ra (
        .clock(clock), .reset(reset), .stall(stall), .branch_en(branch_en),
        .branch_target(branch_target), .call_en(call_en), .ret_en(ret_en),
        .pc_out(pc_out2), .ras_full(full2), .ras_empty(empty2), .ras_err(err2)
    );

    pc_unit #(.WIDTH(8), .RESET_ADDR(8'h0)) dut8 (
        .clock(clock), .reset(reset), .stall(zero), .branch_en(b8_en),
        .branch_target(t8), .call_en(zero), .ret_en(zero),
        .pc_out(pc8), .ras_full(full8), .ras_empty(empty8), .ras_err(err8)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ras(input string tag, input logic full, input logic empty, input logic err);
        check({tag, ".full"},  {31'b0, ras_full},  {31'b0, full});
        check({tag, ".empty"}, {31'b0, ras_empty}, {31'b0, empty});
        check({tag, ".err"},   {31'b0, ras_err},   {31'b0, err});
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_en = 1'b0; call_en = 1'b0; ret_en = 1'b0;
        branch_target = 32'h0; b8_en = 1'b0; zero = 1'b0; t8 = 8'h0;

        tick(); tick();
        check("reset_pc", pc_out, 32'h0);
        check_ras("reset", 1'b0, 1'b1, 1'b0);
        check("reset_pc_0x100", pc_out2, 32'h100);

        reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("idle_inc", pc_out, 32'(i));
        end
        check("idle_inc_0x100", pc_out2, 32'h105);

        reset = 1'b1;
        tick();
        check("reset_mid_run", pc_out, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("run_to_7", pc_out, 32'h7);

        stall = 1'b1; branch_en = 1'b1; branch_target = 32'h40;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", pc_out, 32'h7);
        end
        stall = 1'b0; branch_en = 1'b0;
        tick();
        check("stall_release", pc_out, 32'h8);
        tick(); tick();
        check("at_10", pc_out, 32'hA);

        call_en = 1'b1; branch_target = 32'h40;
        tick();
        call_en = 1'b0;
        check("call_target", pc_out, 32'h40);
`ifdef PC_RAS_EN
        check_ras("after_call", 1'b0, 1'b0, 1'b0);
`else
        check_ras("after_call", 1'b0, 1'b1, 1'b0);
`endif
        tick();
        check("call_body1", pc_out, 32'h41);
        tick();
        check("call_body2", pc_out, 32'h42);
        ret_en = 1'b1;
        tick();
        ret_en = 1'b0;
`ifdef PC_RAS_EN
        check("ret_addr", pc_out, 32'hB);
        check_ras("after_ret", 1'b0, 1'b1, 1'b0);

        // Nested calls from PC 0xB: pushes 0xC, 0x101, 0x201, 0x301, then 0x401 overwrites 0xC.
        for (int i = 1; i <= 5; i++) begin
            call_en = 1'b1; branch_target = 32'(i * 32'h100);
            tick();
            check("nest_call_pc", pc_out, 32'(i * 32'h100));
            if (i == 4) check_ras("call4", 1'b1, 1'b0, 1'b0);
            if (i == 5) check_ras("call5_overflow", 1'b1, 1'b0, 1'b1);
        end
        call_en = 1'b0;
        for (int i = 4; i >= 1; i--) begin
            ret_en = 1'b1;
            tick();
            check("nest_ret_pc", pc_out, 32'(i * 32'h100 + 1));
            check("nest_ret_err", {31'b0, ras_err}, 32'h0);
        end
        check_ras("drained", 1'b0, 1'b1, 1'b0);
        tick();
        ret_en = 1'b0;
        check("ret_empty_pc", pc_out, 32'h102);
        check_ras("ret_empty", 1'b0, 1'b1, 1'b1);
        tick();
        check("err_one_cycle_pc", pc_out, 32'h103);
        check_ras("err_one_cycle", 1'b0, 1'b1, 1'b0);

        branch_en = 1'b1; branch_target = 32'h1F;
        tick();
        branch_en = 1'b0;
        check("branch_1f", pc_out, 32'h1F);
        call_en = 1'b1; branch_target = 32'h60;
        tick();
        check("call_push_20", pc_out, 32'h60);
        ret_en = 1'b1;
        tick();
        call_en = 1'b0; ret_en = 1'b0;
        check("call_ret_pc", pc_out, 32'h20);
        check_ras("call_ret", 1'b0, 1'b1, 1'b1);
`else
        check("ret_ignored", pc_out, 32'h43);
        check_ras("after_ret", 1'b0, 1'b1, 1'b0);
        call_en = 1'b1; ret_en = 1'b1; branch_target = 32'h60;
        tick();
        call_en = 1'b0; ret_en = 1'b0;
        check("call_ret_as_branch", pc_out, 32'h60);
        check_ras("call_ret", 1'b0, 1'b1, 1'b0);
        tick();
        check("after_call_ret", pc_out, 32'h61);
`endif

        b8_en = 1'b1; t8 = 8'hFF;
        tick();
        b8_en = 1'b0;
        check("w8_branch_ff", {24'b0, pc8}, 32'hFF);
        tick();
        check("w8_wrap", {24'b0, pc8}, 32'h00);
        tick();
        check("w8_after_wrap", {24'b0, pc8}, 32'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
